// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source FIFOs for RS and LSB results, one registered broadcast per
// cycle with round-robin on ties. Define CDB_BYPASS_EN to let a result skip an empty FIFO pair.
module cdb_arbiter #(
  parameter int unsigned RoB_WIDTH  = 3,
  parameter int unsigned FIFO_WIDTH = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_signal,
  input  logic                 RS_update_en,
  input  logic [RoB_WIDTH-1:0] RS_update_index,
  input  logic [31:0]          RS_update_data,
  input  logic                 LSB_update_en,
  input  logic [RoB_WIDTH-1:0] LSB_update_index,
  input  logic [31:0]          LSB_update_data,
  output logic                 CDB_update_en,
  output logic [RoB_WIDTH-1:0] CDB_update_index,
  output logic [31:0]          CDB_update_data,
  output logic                 rs_fifo_full,
  output logic                 lsb_fifo_full,
  output logic                 overflow_err
);

  localparam int unsigned Depth  = 1 << FIFO_WIDTH;
  localparam int unsigned EntryW = RoB_WIDTH + 32;
  localparam int unsigned CntW   = FIFO_WIDTH + 1;
  localparam logic        SrcRs  = 1'b0;
  localparam logic        SrcLsb = 1'b1;

  // Source 0 is the RS FIFO, source 1 the LSB FIFO.
  logic [EntryW-1:0]     mem_q  [2][Depth];
  logic [EntryW-1:0]     mem_d  [2][Depth];
  logic [FIFO_WIDTH-1:0] head_q [2];
  logic [FIFO_WIDTH-1:0] head_d [2];
  logic [FIFO_WIDTH-1:0] tail_q [2];
  logic [FIFO_WIDTH-1:0] tail_d [2];
  logic [CntW-1:0]       cnt_q  [2];
  logic [CntW-1:0]       cnt_d  [2];

  logic                  cdb_en_q, cdb_en_d;
  logic [RoB_WIDTH-1:0]  cdb_idx_q, cdb_idx_d;
  logic [31:0]           cdb_data_q, cdb_data_d;
  logic                  ovf_q, ovf_d;
  logic                  last_grant_q, last_grant_d;

  logic                  push_en   [2];
  logic [EntryW-1:0]     push_word [2];
  logic                  pop       [2];
  logic                  push_acc  [2];
  logic                  nonempty  [2];
  logic                  grant;
  logic                  do_pop;
  logic                  bypass;
  logic [EntryW-1:0]     out_word;

  always_comb begin
    push_en[0]   = RS_update_en;
    push_en[1]   = LSB_update_en;
    push_word[0] = {RS_update_index, RS_update_data};
    push_word[1] = {LSB_update_index, LSB_update_data};

    mem_d        = mem_q;
    head_d       = head_q;
    tail_d       = tail_q;
    cnt_d        = cnt_q;
    cdb_en_d     = cdb_en_q;
    cdb_idx_d    = cdb_idx_q;
    cdb_data_d   = cdb_data_q;
    ovf_d        = ovf_q;
    last_grant_d = last_grant_q;
    grant        = SrcRs;
    do_pop       = 1'b0;
    bypass       = 1'b0;
    out_word     = '0;
    for (int s = 0; s < 2; s++) begin
      pop[s]      = 1'b0;
      push_acc[s] = 1'b0;
      nonempty[s] = (cnt_q[s] != '0);
    end

    if (!rdy_in) begin
      // Paused: hold everything.
    end else if (flush_signal) begin
      for (int s = 0; s < 2; s++) begin
        head_d[s] = '0;
        tail_d[s] = '0;
        cnt_d[s]  = '0;
      end
      cdb_en_d = 1'b0;
    end else begin
      cdb_en_d = 1'b0;
      if (nonempty[0] && nonempty[1]) begin
        do_pop = 1'b1;
        grant  = (last_grant_q == SrcLsb) ? SrcRs : SrcLsb;
      end else if (nonempty[0] || nonempty[1]) begin
        do_pop = 1'b1;
        grant  = nonempty[0] ? SrcRs : SrcLsb;
      end
`ifdef CDB_BYPASS_EN
      else if (push_en[0] || push_en[1]) begin
        bypass = 1'b1;
        if (push_en[0] && push_en[1]) grant = (last_grant_q == SrcLsb) ? SrcRs : SrcLsb;
        else                          grant = push_en[0] ? SrcRs : SrcLsb;
      end
`endif

      if (do_pop) begin
        pop[grant]    = 1'b1;
        out_word      = mem_q[grant][head_q[grant]];
        head_d[grant] = head_q[grant] + 1'b1;
      end else if (bypass) begin
        out_word = push_word[grant];
      end

      if (do_pop || bypass) begin
        cdb_en_d     = 1'b1;
        cdb_idx_d    = out_word[EntryW-1:32];
        cdb_data_d   = out_word[31:0];
        last_grant_d = grant;
      end

      for (int s = 0; s < 2; s++) begin
        if (push_en[s] && !(bypass && (grant == s[0]))) begin
          // A full FIFO can still accept when its head leaves this same cycle.
          if (cnt_q[s] != CntW'(Depth) || pop[s]) begin
            push_acc[s]            = 1'b1;
            mem_d[s][tail_q[s]]    = push_word[s];
            tail_d[s]              = tail_q[s] + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        cnt_d[s] = cnt_q[s] + CntW'(push_acc[s]) - CntW'(pop[s]);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int s = 0; s < 2; s++) begin
        head_q[s] <= '0;
        tail_q[s] <= '0;
        cnt_q[s]  <= '0;
      end
      cdb_en_q     <= 1'b0;
      cdb_idx_q    <= '0;
      cdb_data_q   <= '0;
      ovf_q        <= 1'b0;
      last_grant_q <= SrcLsb;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      cnt_q        <= cnt_d;
      cdb_en_q     <= cdb_en_d;
      cdb_idx_q    <= cdb_idx_d;
      cdb_data_q   <= cdb_data_d;
      ovf_q        <= ovf_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Storage needs no reset; validity is tracked by the counts.
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  assign CDB_update_en    = cdb_en_q;
  assign CDB_update_index = cdb_idx_q;
  assign CDB_update_data  = cdb_data_q;
  assign rs_fifo_full     = (cnt_q[0] >= CntW'(Depth - 1));
  assign lsb_fifo_full    = (cnt_q[1] >= CntW'(Depth - 1));
  assign overflow_err     = ovf_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter against a queue-based model of the broadcast rules.
module tb_cdb_arbiter;

  localparam int RW    = 3;
  localparam int DEPTH = 4;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, flush_signal;
  logic          RS_update_en, LSB_update_en;
  logic [RW-1:0] RS_update_index, LSB_update_index;
  logic [31:0]   RS_update_data, LSB_update_data;
  logic          CDB_update_en;
  logic [RW-1:0] CDB_update_index;
  logic [31:0]   CDB_update_data;
  logic          rs_fifo_full, lsb_fifo_full, overflow_err;

  int total = 0;
  int bad   = 0;

  // Model state: one queue per source, last winner (0 = RS, 1 = LSB), expected outputs.
  logic [RW+31:0] rq[$];
  logic [RW+31:0] lq[$];
  bit             m_lg;
  logic           m_en, m_ovf;
  logic [RW-1:0]  m_idx;
  logic [31:0]    m_data;
  int             pulses_idx7;

  cdb_arbiter #(.RoB_WIDTH(RW), .FIFO_WIDTH(2)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .flush_signal     (flush_signal),
    .RS_update_en     (RS_update_en),
    .RS_update_index  (RS_update_index),
    .RS_update_data   (RS_update_data),
    .LSB_update_en    (LSB_update_en),
    .LSB_update_index (LSB_update_index),
    .LSB_update_data  (LSB_update_data),
    .CDB_update_en    (CDB_update_en),
    .CDB_update_index (CDB_update_index),
    .CDB_update_data  (CDB_update_data),
    .rs_fifo_full     (rs_fifo_full),
    .lsb_fifo_full    (lsb_fifo_full),
    .overflow_err     (overflow_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    int rn, ln;
    bit pr, pl, br, bl;
    logic [RW+31:0] w;
    if (!rst_in) begin
      rq.delete(); lq.delete();
      m_en = 0; m_idx = '0; m_data = '0; m_ovf = 0; m_lg = 1;
    end else if (!rdy_in) begin
    end else if (flush_signal) begin
      rq.delete(); lq.delete();
      m_en = 0;
    end else begin
      rn = rq.size(); ln = lq.size();
      pr = 0; pl = 0; br = 0; bl = 0; w = '0;
      m_en = 0;
      if (rn > 0 && ln > 0) begin
        if (m_lg) pr = 1; else pl = 1;
      end else if (rn > 0) pr = 1;
      else if (ln > 0) pl = 1;
`ifdef CDB_BYPASS_EN
      else if (RS_update_en && LSB_update_en) begin
        if (m_lg) br = 1; else bl = 1;
      end else if (RS_update_en) br = 1;
      else if (LSB_update_en) bl = 1;
`endif
      if (pr) w = rq.pop_front();
      if (pl) w = lq.pop_front();
      if (br) w = {RS_update_index, RS_update_data};
      if (bl) w = {LSB_update_index, LSB_update_data};
      if (pr || pl || br || bl) begin
        m_en = 1; m_idx = w[RW+31:32]; m_data = w[31:0];
        m_lg = pl || bl;
      end
      if (RS_update_en && !br) begin
        if (rn < DEPTH || pr) rq.push_back({RS_update_index, RS_update_data});
        else m_ovf = 1;
      end
      if (LSB_update_en && !bl) begin
        if (ln < DEPTH || pl) lq.push_back({LSB_update_index, LSB_update_data});
        else m_ovf = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_edge();
    #1;
    if (CDB_update_en === 1'b1 && CDB_update_index === 3'd7 && m_en == 0) pulses_idx7++;
    check_val("cdb_en", 64'(CDB_update_en), 64'(m_en));
    check_val("cdb_index", 64'(CDB_update_index), 64'(m_idx));
    check_val("cdb_data", 64'(CDB_update_data), 64'(m_data));
    check_val("rs_full", 64'(rs_fifo_full), 64'(rq.size() >= DEPTH - 1));
    check_val("lsb_full", 64'(lsb_fifo_full), 64'(lq.size() >= DEPTH - 1));
    check_val("overflow", 64'(overflow_err), 64'(m_ovf));
  endtask

  task automatic drive(input bit rse, input int rsi, input bit lse, input int lsi);
    RS_update_en     = rse;
    RS_update_index  = RW'(rsi);
    RS_update_data   = $urandom;
    LSB_update_en    = lse;
    LSB_update_index = RW'(lsi);
    LSB_update_data  = $urandom;
  endtask

  initial begin
    bit honour;
    rst_in = 0; rdy_in = 1; flush_signal = 0; pulses_idx7 = 0;
    m_lg = 1; m_en = 0; m_ovf = 0; m_idx = '0; m_data = '0;
    drive(1, 1, 1, 2);
    @(negedge clk_in);
    tick(); tick();

    // Single RS result.
    rst_in = 1;
    drive(1, 3, 0, 0);
    RS_update_data = 32'h1234;
    tick();
    drive(0, 0, 0, 0);
    repeat (4) tick();

    // Both sources every cycle for six cycles.
    for (int i = 0; i < 6; i++) begin
      drive(1, i, 1, i);
      tick();
    end
    drive(0, 0, 0, 0);
    repeat (10) tick();

    // Ignore full flags until a FIFO overflows; the error must stick.
    for (int i = 0; i < 14; i++) begin
      drive(1, i, 1, i + 1);
      tick();
    end
    drive(0, 0, 0, 0);
    repeat (12) tick();

    // Fill then flush together with an RS push of index 7.
    rst_in = 0; tick(); rst_in = 1;
    for (int i = 0; i < 6; i++) begin
      drive(1, i % 7, 1, i % 7);
      tick();
    end
    flush_signal = 1;
    drive(1, 7, 0, 0);
    tick();
    flush_signal = 0;
    drive(0, 0, 0, 0);
    repeat (6) tick();
    check_val("idx7_never_sent", 64'(pulses_idx7), 64'd0);

    // Pause mid-stream with pushes asserted.
    for (int i = 0; i < 10; i++) begin
      rdy_in = !(i >= 3 && i < 6);
      drive(i % 2 == 0, i, i % 3 == 0, i + 2);
      tick();
    end
    rdy_in = 1;
    drive(0, 0, 0, 0);
    repeat (8) tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      honour       = ($urandom_range(0, 9) != 0);
      rst_in       = ($urandom_range(0, 199) != 0);
      rdy_in       = ($urandom_range(0, 9) != 0);
      flush_signal = ($urandom_range(0, 39) == 0);
      drive(($urandom_range(0, 2) != 0) && (!honour || rq.size() < DEPTH - 1), $urandom,
            ($urandom_range(0, 2) != 0) && (!honour || lq.size() < DEPTH - 1), $urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
